// File: rtl/text_scan_pkg.sv
// Shared types and byte constants for the marker-text scanner.
// String-literal states exist only when TEXT_SCAN_STRING_EN is defined.
package text_scan_pkg;

  typedef enum logic [1:0] {
    CTX_CODE      = 2'd0,
    CTX_LINE_CMT  = 2'd1,
    CTX_BLOCK_CMT = 2'd2,
    CTX_STRING    = 2'd3
  } ctx_e;

  typedef enum logic [2:0] {
    ST_CODE,
    ST_SLASH,
    ST_LINE_CMT,
    ST_BLOCK_CMT,
    ST_BLOCK_STAR
`ifdef TEXT_SCAN_STRING_EN
    ,
    ST_STRING,
    ST_STR_ESC
`endif
  } state_e;

  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_NL     = 8'h0A;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_BSLASH = 8'h5C;

  // A byte seen in SLASH is code; a byte seen in BLOCK_STAR is still comment.
  function automatic ctx_e state_ctx(input state_e s);
    ctx_e c;
    c = CTX_CODE;
    case (s)
      ST_LINE_CMT:   c = CTX_LINE_CMT;
      ST_BLOCK_CMT:  c = CTX_BLOCK_CMT;
      ST_BLOCK_STAR: c = CTX_BLOCK_CMT;
`ifdef TEXT_SCAN_STRING_EN
      ST_STRING:     c = CTX_STRING;
      ST_STR_ESC:    c = CTX_STRING;
`endif
      default:       c = CTX_CODE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/text_scan_matcher.sv
// Counts consecutive marker bytes, latches the column of the first one,
// and flags a hit on the byte that completes a run of RUN_LEN.
module text_scan_matcher
  import text_scan_pkg::*;
#(
  parameter int          COL_W   = 12,
  parameter logic [7:0]  MARK    = 8'h58,
  parameter int          RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data,
  input  logic             accept,
  input  logic             clear,
  input  logic [COL_W-1:0] col,
  output logic             hit,
  output logic [COL_W-1:0] hit_col
);

  localparam logic [2:0] LAST = 3'(RUN_LEN - 1);

  logic [2:0]       run_reg;
  logic [COL_W-1:0] first_col_reg;
  logic             is_mark;

  assign is_mark = (data == MARK);
  // RUN_LEN >= 2, so the first column is always latched before a hit.
  assign hit     = accept && is_mark && (run_reg == LAST);
  assign hit_col = first_col_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg       <= '0;
      first_col_reg <= '0;
    end else begin
      if (clear) begin
        run_reg <= '0;
      end else if (accept) begin
        if (!is_mark || hit) run_reg <= '0;
        else                 run_reg <= run_reg + 3'd1;
      end
      if (accept && is_mark && (run_reg == '0)) first_col_reg <= col;
    end
  end

endmodule

// File: rtl/text_mark_scanner.sv
// Streaming scanner reporting runs of marker bytes with line, column and
// lexical context. Define TEXT_SCAN_STRING_EN to track string literals.
module text_mark_scanner
  import text_scan_pkg::*;
#(
  parameter int         LINE_W  = 16,
  parameter int         COL_W   = 12,
  parameter int         CNT_W   = 16,
  parameter logic [7:0] MARK    = 8'h58,
  parameter int         RUN_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LINE_W-1:0] m_line,
  output logic [COL_W-1:0]  m_col,
  output logic [1:0]        m_ctx,
  output logic              done,
  output logic [CNT_W-1:0]  done_count
);

  state_e            state_reg, state_next, code_next;
  logic              ready_en_reg;
  logic [LINE_W-1:0] line_reg;
  logic [COL_W-1:0]  col_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_plus;
  logic              m_valid_reg;
  logic [LINE_W-1:0] m_line_reg;
  logic [COL_W-1:0]  m_col_reg;
  ctx_e              m_ctx_reg;
  logic              done_reg;
  logic [CNT_W-1:0]  done_count_reg;
  logic              accept, hit;
  logic [COL_W-1:0]  hit_col;
  ctx_e              byte_ctx;

  // s_ready stays low until the first clock after reset release.
  assign s_ready    = ready_en_reg && (!m_valid_reg || m_ready);
  assign accept     = s_valid && s_ready;
  assign byte_ctx   = state_ctx(state_reg);
  assign cnt_plus   = (hit && (cnt_reg != '1)) ? cnt_reg + CNT_W'(1) : cnt_reg;

  assign m_valid    = m_valid_reg;
  assign m_line     = m_line_reg;
  assign m_col      = m_col_reg;
  assign m_ctx      = m_ctx_reg;
  assign done       = done_reg;
  assign done_count = done_count_reg;

  text_scan_matcher #(
    .COL_W   (COL_W),
    .MARK    (MARK),
    .RUN_LEN (RUN_LEN)
  ) u_matcher (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (s_data),
    .accept  (accept),
    .clear   (accept && s_last),
    .col     (col_reg),
    .hit     (hit),
    .hit_col (hit_col)
  );

  always_comb begin
    code_next  = ST_CODE;
    state_next = state_reg;
    if (s_data == CH_SLASH) code_next = ST_SLASH;
`ifdef TEXT_SCAN_STRING_EN
    else if (s_data == CH_QUOTE) code_next = ST_STRING;
`endif
    if (accept) begin
      if (s_last) begin
        state_next = ST_CODE;
      end else begin
        case (state_reg)
          ST_CODE:  state_next = code_next;
          ST_SLASH: begin
            if (s_data == CH_SLASH)     state_next = ST_LINE_CMT;
            else if (s_data == CH_STAR) state_next = ST_BLOCK_CMT;
            else                        state_next = code_next;
          end
          ST_LINE_CMT:  if (s_data == CH_NL) state_next = ST_CODE;
          ST_BLOCK_CMT: if (s_data == CH_STAR) state_next = ST_BLOCK_STAR;
          ST_BLOCK_STAR: begin
            if (s_data == CH_SLASH)     state_next = ST_CODE;
            else if (s_data != CH_STAR) state_next = ST_BLOCK_CMT;
          end
`ifdef TEXT_SCAN_STRING_EN
          ST_STRING: begin
            if (s_data == CH_BSLASH)                        state_next = ST_STR_ESC;
            else if (s_data == CH_QUOTE || s_data == CH_NL) state_next = ST_CODE;
          end
          ST_STR_ESC: state_next = ST_STRING;
`endif
          default: state_next = ST_CODE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CODE;
      ready_en_reg <= 1'b0;
      line_reg     <= LINE_W'(1);
      col_reg      <= COL_W'(1);
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      if (accept) begin
        if (s_last) begin
          line_reg <= LINE_W'(1);
          col_reg  <= COL_W'(1);
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_plus;
          if (s_data == CH_NL) begin
            if (line_reg != '1) line_reg <= line_reg + LINE_W'(1);
            col_reg <= COL_W'(1);
          end else if (col_reg != '1) begin
            col_reg <= col_reg + COL_W'(1);
          end
        end
      end
    end
  end

  // A run cannot span a newline, so the current line is the hit's line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg    <= 1'b0;
      m_line_reg     <= '0;
      m_col_reg      <= '0;
      m_ctx_reg      <= CTX_CODE;
      done_reg       <= 1'b0;
      done_count_reg <= '0;
    end else begin
      if (hit) begin
        m_valid_reg <= 1'b1;
        m_line_reg  <= line_reg;
        m_col_reg   <= hit_col;
        m_ctx_reg   <= byte_ctx;
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
      done_reg <= accept && s_last;
      if (accept && s_last) done_count_reg <= cnt_plus;
    end
  end

endmodule

// File: doc/text_mark_scanner.md
# text_mark_scanner

Streaming lexical scanner that inspects HDL source bytes for forbidden marker text (a run of `X` characters) and reports every hit with line, column and lexical context (code, line comment, block comment). It sits behind the file-read DMA in the lint accelerator and feeds the rule-report queue. It owns the comment-context state machine and sequences a shared run matcher. Producers are throttled by a one-entry hit buffer.

## Interface
- LINE_W, 16: line counter width.
- COL_W, 12: column counter width.
- CNT_W, 16: per-file hit counter width.
- MARK, 8'h58: marker byte (`X`, case-sensitive).
- RUN_LEN, 3: consecutive marker bytes forming one hit (2..7).
- clk  input  1  clock; all state rises on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  source byte valid.
- s_ready  output  1  scanner accepts byte; reset 0, then 1.
- s_data  input  8  source byte.
- s_last  input  1  byte is the last of the file.
- m_valid  output  1  hit record valid; reset 0.
- m_ready  input  1  consumer accepts hit.
- m_line  output  LINE_W  line of first marker byte of hit, 1-based; reset 0.
- m_col  output  COL_W  column of first marker byte, 1-based; reset 0.
- m_ctx  output  2  context at hit: 0 CODE, 1 LINE_CMT, 2 BLOCK_CMT, 3 STRING; reset 0.
- done  output  1  one-cycle pulse after s_last byte accepted; reset 0.
- done_count  output  CNT_W  hits in the finished file, saturating; valid with done; reset 0.

## Operation
- Byte accepted when s_valid && s_ready. s_ready = !m_valid || m_ready.
- Context FSM states: CODE, SLASH, LINE_CMT, BLOCK_CMT, BLOCK_STAR (plus STRING, see Configuration).
  - CODE: `/` -> SLASH; else stay.
  - SLASH: `/` -> LINE_CMT; `*` -> BLOCK_CMT; other byte -> CODE and that byte is processed as CODE, including marker counting.
  - LINE_CMT: `\n` -> CODE; else stay.
  - BLOCK_CMT: `*` -> BLOCK_STAR; else stay. Newlines do not exit.
  - BLOCK_STAR: `/` -> CODE; `*` stay; other -> BLOCK_CMT. `/*/` does not close.
- Run matcher:
  - MARK increments run; the column of the first MARK is latched.
  - Any other byte clears run.
  - When run reaches RUN_LEN: emit hit and clear run. Hits are non-overlapping; "XXXXXX" gives 2 hits.
  - m_ctx is the context in effect when the final marker byte is accepted.
- Position counters:
  - line starts at 1; col starts at 1 and advances per accepted byte.
  - `\n` increments line and sets col to 1 for the next byte.
  - Both saturate at all-ones.
- Hit counter increments per hit and saturates at all-ones.
- s_last, applied after processing its byte:
  - FSM -> CODE; line/col -> 1; run -> 0; hit counter cleared after done_count is captured.
  - Unterminated comments are discarded silently.

## Timing
- Hit record appears on m_val/m_line/m_col/m_ctx the cycle after the final marker byte is accepted. It holds stable until m_valid && m_ready.
- Throughput is one byte per cycle while m_ready is high. After a hit with m_ready low, s_ready drops the next cycle.
- done pulses the cycle after the s_last byte is accepted. done_count includes a hit completed by that same byte.
- Reset mid-file aborts everything: outputs go to their reset values; a pending hit is lost.

## Configuration
- TEXT_SCAN_STRING_EN defined:
  - `"` in CODE enters STRING.
  - `\` in STRING makes the next byte literal.
  - `"` exits STRING to CODE; `\n` also exits STRING to CODE.
  - Hits in strings report m_ctx=3.
  - `//` and `/*` inside a string open no comment.
- Not defined: no STRING state; `"` is an ordinary CODE byte, and m_ctx=3 is never produced.

## Structure
- Package text_scan_pkg: ctx_e enum (CODE, LINE_CMT, BLOCK_CMT, STRING), fsm state enum, and byte constants for `/`, `*`, `\n`, `"`, `\`.
- Sub-module text_scan_matcher: run counter plus first-column latch, with inputs byte/accept/clear and a hit output. It is instantiated once.

## Test plan
- Feed "module M; // XXX bad\n" with m_ready=1 -> one hit: line 1, col 14, ctx 1.
- Feed "module M;\n  /* XXX */\n" -> hit line 2, col 6, ctx 2. A following "  a = XX;" -> no hit.
- Feed "  always_comb a = XXX;" with s_last on `;` -> hit line 1, col 19, ctx 0. Next cycle done=1, done_count=1.
- Feed "XXXXXXX" with m_ready=0 -> s_ready drops after the first hit. Release m_ready -> exactly 2 hits, cols 1 and 4.
- Feed "/X/XXX" then "/*/ XXX */" -> ctx 0 hit at col 4. The second line yields ctx 2; its comment stays open until `*/`.
- With TEXT_SCAN_STRING_EN, feed `s = "//XXX";` -> hit col 8, ctx 3. The next line starts in CODE. Without the macro, the same input gives ctx 1.
